// File: rtl/gpu_framebuffer_if.sv
// rtl/gpu_framebuffer_if.sv - GPU write, scan-out read and swap-control signal bundle
interface gpu_framebuffer_if #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240
);
    localparam int XW = $clog2(FB_WIDTH) + 1;
    localparam int YW = $clog2(FB_HEIGHT) + 1;

    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic [15:0]   fb_color;
    logic          fb_write;
    logic [XW-1:0] disp_x;
    logic [YW-1:0] disp_y;
    logic          disp_read;
    logic          disp_vblank;
    logic [15:0]   disp_color;
    logic          disp_valid;
    logic          ctrl_swap;
    logic          swap_pending;
    logic          swap_done;
    logic          front_sel;

    modport master (
        output fb_x, fb_y, fb_color, fb_write,
        output disp_x, disp_y, disp_read, disp_vblank, ctrl_swap,
        input  disp_color, disp_valid, swap_pending, swap_done, front_sel
    );

    modport slave (
        input  fb_x, fb_y, fb_color, fb_write,
        input  disp_x, disp_y, disp_read, disp_vblank, ctrl_swap,
        output disp_color, disp_valid, swap_pending, swap_done, front_sel
    );
endinterface

// File: rtl/gpu_framebuffer.sv
// rtl/gpu_framebuffer.sv - double-buffered pixel store with vblank-synchronised swap
module gpu_framebuffer #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240
) (
    input  logic            clk,
    input  logic            reset,
    gpu_framebuffer_if.slave fb
);
    localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(FB_WIDTH) + 1;
    localparam int YW    = $clog2(FB_HEIGHT) + 1;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [31:0] a;
        a = 32'(y) * 32'(FB_WIDTH) + 32'(x);
        return a[AW-1:0];
    endfunction

    logic [15:0] mem0 [DEPTH];
    logic [15:0] mem1 [DEPTH];

    state_t  state_q, state_d;
    logic    front_sel_q, front_sel_d;
    logic    swap_done_q, swap_done_d;
    logic    swap_in_q, swap_in_d;
    logic    vblank_in_q, vblank_in_d;
    logic    swap_rise, vblank_rise, do_swap, swap_pending;

    logic          w1_valid_q, w1_valid_d;
    logic [AW-1:0] w1_addr_q, w1_addr_d;
    logic [15:0]   w1_color_q, w1_color_d;
    logic          w1_buf_q, w1_buf_d;

    logic          r1_valid_q, r1_valid_d;
    logic [AW-1:0] r1_addr_q, r1_addr_d;
    logic          r1_buf_q, r1_buf_d;
    logic          r1_oor_q, r1_oor_d;
    logic          r2_valid_q, r2_valid_d;
    logic [15:0]   r2_data_q, r2_data_d;
    logic          disp_valid_q, disp_valid_d;
    logic [15:0]   disp_color_q, disp_color_d;
    logic [15:0]   ram_rdata;
    logic          wr_in_range, rd_in_range;

    assign swap_rise   = fb.ctrl_swap & ~swap_in_q;
    assign vblank_rise = fb.disp_vblank & ~vblank_in_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            front_sel_q  <= 1'b0;
            swap_done_q  <= 1'b0;
            swap_in_q    <= 1'b0;
            vblank_in_q  <= 1'b0;
            w1_valid_q   <= 1'b0;
            w1_addr_q    <= '0;
            w1_color_q   <= '0;
            w1_buf_q     <= 1'b0;
            r1_valid_q   <= 1'b0;
            r1_addr_q    <= '0;
            r1_buf_q     <= 1'b0;
            r1_oor_q     <= 1'b0;
            r2_valid_q   <= 1'b0;
            r2_data_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_color_q <= '0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            swap_done_q  <= swap_done_d;
            swap_in_q    <= swap_in_d;
            vblank_in_q  <= vblank_in_d;
            w1_valid_q   <= w1_valid_d;
            w1_addr_q    <= w1_addr_d;
            w1_color_q   <= w1_color_d;
            w1_buf_q     <= w1_buf_d;
            r1_valid_q   <= r1_valid_d;
            r1_addr_q    <= r1_addr_d;
            r1_buf_q     <= r1_buf_d;
            r1_oor_q     <= r1_oor_d;
            r2_valid_q   <= r2_valid_d;
            r2_data_q    <= r2_data_d;
            disp_valid_q <= disp_valid_d;
            disp_color_q <= disp_color_d;
        end
    end

    // A request and a vblank edge in the same cycle swap immediately.
    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (swap_rise) begin
                    if (vblank_rise) do_swap = 1'b1;
                    else             state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (vblank_rise) begin
                    do_swap = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        front_sel_d  = front_sel_q ^ do_swap;
        swap_done_d  = do_swap;
        swap_in_d    = fb.ctrl_swap;
        vblank_in_d  = fb.disp_vblank;
        swap_pending = (state_q == S_PENDING);
    end

    // Write capture latches the back buffer seen now, so a swap on this edge cannot redirect it.
    always_comb begin
        wr_in_range = (32'(fb.fb_x) < 32'(FB_WIDTH)) && (32'(fb.fb_y) < 32'(FB_HEIGHT));
        w1_valid_d  = fb.fb_write & wr_in_range;
        w1_addr_d   = w1_addr_q;
        w1_color_d  = w1_color_q;
        w1_buf_d    = w1_buf_q;
        if (fb.fb_write && wr_in_range) begin
            w1_addr_d  = pix_addr(fb.fb_x, fb.fb_y);
            w1_color_d = fb.fb_color;
            w1_buf_d   = ~front_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (w1_valid_q) begin
            if (w1_buf_q) mem1[w1_addr_q] <= w1_color_q;
            else          mem0[w1_addr_q] <= w1_color_q;
        end
    end

    assign ram_rdata = r1_buf_q ? mem1[r1_addr_q] : mem0[r1_addr_q];

    always_comb begin
        rd_in_range  = (32'(fb.disp_x) < 32'(FB_WIDTH)) && (32'(fb.disp_y) < 32'(FB_HEIGHT));
        r1_valid_d   = fb.disp_read;
        r1_addr_d    = r1_addr_q;
        r1_buf_d     = r1_buf_q;
        r1_oor_d     = r1_oor_q;
        if (fb.disp_read) begin
            r1_addr_d = rd_in_range ? pix_addr(fb.disp_x, fb.disp_y) : '0;
            r1_buf_d  = front_sel_q;
            r1_oor_d  = ~rd_in_range;
        end
        r2_valid_d   = r1_valid_q;
        r2_data_d    = r1_valid_q ? (r1_oor_q ? 16'h0000 : ram_rdata) : r2_data_q;
        disp_valid_d = r2_valid_q;
        disp_color_d = r2_valid_q ? r2_data_q : disp_color_q;
    end

    assign fb.disp_color   = disp_color_q;
    assign fb.disp_valid   = disp_valid_q;
    assign fb.swap_pending = swap_pending;
    assign fb.swap_done    = swap_done_q;
    assign fb.front_sel    = front_sel_q;
endmodule

// File: tb/tb_gpu_framebuffer.sv
// tb/tb_gpu_framebuffer.sv - directed self-checking bench for gpu_framebuffer
module tb_gpu_framebuffer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [15:0] rdata;

    always #5 clk = ~clk;

    gpu_framebuffer_if #(.FB_WIDTH(400), .FB_HEIGHT(240)) bus ();

    gpu_framebuffer #(.FB_WIDTH(400), .FB_HEIGHT(240)) dut (
        .clk   (clk),
        .reset (reset),
        .fb    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] x, input logic [8:0] y, input logic [15:0] c);
        bus.fb_x = x; bus.fb_y = y; bus.fb_color = c; bus.fb_write = 1'b1;
        tick();
        bus.fb_write = 1'b0;
    endtask

    task automatic rd(input logic [8:0] x, input logic [8:0] y, output logic [15:0] data);
        bus.disp_x = x; bus.disp_y = y; bus.disp_read = 1'b1;
        tick();
        bus.disp_read = 1'b0;
        tick();
        check("rd_early", 32'(bus.disp_valid), 32'd0);
        tick();
        check("rd_valid", 32'(bus.disp_valid), 32'd1);
        data = bus.disp_color;
    endtask

    task automatic swap_req();
        bus.ctrl_swap = 1'b1;
        tick();
        bus.ctrl_swap = 1'b0;
        tick();
    endtask

    task automatic vblank(input logic exp_front, input logic exp_done);
        bus.disp_vblank = 1'b1;
        tick();
        check("vb_front", 32'(bus.front_sel), 32'(exp_front));
        check("vb_done", 32'(bus.swap_done), 32'(exp_done));
        bus.disp_vblank = 1'b0;
        tick();
        check("vb_done_clr", 32'(bus.swap_done), 32'd0);
    endtask

    initial begin
        bus.fb_x = '0; bus.fb_y = '0; bus.fb_color = '0; bus.fb_write = 1'b0;
        bus.disp_x = '0; bus.disp_y = '0; bus.disp_read = 1'b0;
        bus.disp_vblank = 1'b0; bus.ctrl_swap = 1'b0;

        repeat (3) tick();
        check("rst_front", 32'(bus.front_sel), 32'd0);
        check("rst_pending", 32'(bus.swap_pending), 32'd0);
        check("rst_valid", 32'(bus.disp_valid), 32'd0);
        check("rst_color", 32'(bus.disp_color), 32'd0);
        check("rst_done", 32'(bus.swap_done), 32'd0);
        reset = 1'b1;
        tick();

        // back = 1
        wr(9'd10, 9'd20, 16'hABCD);
        swap_req();
        check("pend_set", 32'(bus.swap_pending), 32'd1);
        vblank(1'b1, 1'b1);
        check("pend_clr", 32'(bus.swap_pending), 32'd0);
        rd(9'd10, 9'd20, rdata);
        check("rd_10_20", 32'(rdata), 32'hABCD);
        check("front_after", 32'(bus.front_sel), 32'd1);

        // back = 0; aliased out-of-range write must be dropped
        wr(9'd0, 9'd6, 16'h2222);
        wr(9'd400, 9'd5, 16'hFFFF);
        wr(9'd5, 9'd240, 16'hEEEE);
        rd(9'd400, 9'd0, rdata);
        check("rd_oor", 32'(rdata), 32'h0000);
        swap_req();
        vblank(1'b0, 1'b1);
        rd(9'd0, 9'd6, rdata);
        check("rd_alias", 32'(rdata), 32'h2222);

        // request and vblank edge together
        bus.ctrl_swap = 1'b1; bus.disp_vblank = 1'b1;
        tick();
        check("same_front", 32'(bus.front_sel), 32'd1);
        check("same_done", 32'(bus.swap_done), 32'd1);
        check("same_pend", 32'(bus.swap_pending), 32'd0);
        bus.ctrl_swap = 1'b0; bus.disp_vblank = 1'b0;
        tick();

        // second request while pending: one toggle only
        swap_req();
        swap_req();
        check("dbl_pend", 32'(bus.swap_pending), 32'd1);
        vblank(1'b0, 1'b1);
        vblank(1'b0, 1'b0);

        // back = 1: boundary pixel and in-flight guard value
        wr(9'd399, 9'd239, 16'h1235);
        wr(9'd7, 9'd7, 16'h7777);
        swap_req();
        vblank(1'b1, 1'b1);
        rd(9'd399, 9'd239, rdata);
        check("rd_corner", 32'(rdata), 32'h1235);

        // write captured on the vblank edge lands in old back (buffer 0)
        swap_req();
        bus.fb_x = 9'd7; bus.fb_y = 9'd7; bus.fb_color = 16'hBEEF; bus.fb_write = 1'b1;
        bus.disp_vblank = 1'b1;
        tick();
        check("inflt_front", 32'(bus.front_sel), 32'd0);
        bus.fb_write = 1'b0; bus.disp_vblank = 1'b0;
        tick();
        rd(9'd7, 9'd7, rdata);
        check("inflt_old_back", 32'(rdata), 32'hBEEF);
        swap_req();
        vblank(1'b1, 1'b1);
        rd(9'd7, 9'd7, rdata);
        check("inflt_new_back", 32'(rdata), 32'h7777);

        // back-to-back reads, front = 1
        bus.disp_x = 9'd10;  bus.disp_y = 9'd20;  bus.disp_read = 1'b1; tick();
        bus.disp_x = 9'd399; bus.disp_y = 9'd239; tick();
        bus.disp_x = 9'd7;   bus.disp_y = 9'd7;   tick();
        bus.disp_read = 1'b0;
        check("pipe0_v", 32'(bus.disp_valid), 32'd1);
        check("pipe0_d", 32'(bus.disp_color), 32'hABCD);
        tick();
        check("pipe1_v", 32'(bus.disp_valid), 32'd1);
        check("pipe1_d", 32'(bus.disp_color), 32'h1235);
        tick();
        check("pipe2_v", 32'(bus.disp_valid), 32'd1);
        check("pipe2_d", 32'(bus.disp_color), 32'h7777);
        tick();
        check("pipe_end", 32'(bus.disp_valid), 32'd0);

        // reset mid-flight drops the queued read
        bus.disp_x = 9'd10; bus.disp_y = 9'd20; bus.disp_read = 1'b1;
        tick();
        bus.disp_read = 1'b0;
        reset = 1'b0;
        #1;
        check("mrst_front", 32'(bus.front_sel), 32'd0);
        check("mrst_valid", 32'(bus.disp_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("mrst_drop", 32'(bus.disp_valid), 32'd0);
        check("mrst_color", 32'(bus.disp_color), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_framebuffer.md
# gpu_framebuffer

Double-buffered pixel store directly downstream of the GPU draw/clear engine. It accepts the GPU's per-pixel write strobes (x, y, color) into the back buffer and serves the display scan-out from the front buffer. Front and back are exchanged on request, synchronised to the display's vertical blank so scan-out never tears.

## Interface

Parameters:
- FB_WIDTH, 400, horizontal resolution in pixels.
- FB_HEIGHT, 240, vertical resolution in pixels.
- Derived (localparam): AW = $clog2(FB_WIDTH*FB_HEIGHT), the word-address width of one buffer.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- fb_x  in  $clog2(FB_WIDTH)+1  write x coordinate (GPU side).
- fb_y  in  $clog2(FB_HEIGHT)+1  write y coordinate.
- fb_color  in  16  pixel color, RGB555 plus transparency bit 0; stored verbatim.
- fb_write  in  1  write strobe; one pixel per cycle it is high.
- disp_x  in  $clog2(FB_WIDTH)+1  scan-out x coordinate.
- disp_y  in  $clog2(FB_HEIGHT)+1  scan-out y coordinate.
- disp_read  in  1  scan-out read strobe.
- disp_vblank  in  1  display vertical-blank level.
- disp_color  out  16  front-buffer pixel.
- disp_valid  out  1  disp_color valid pulse.
- ctrl_swap  in  1  swap request; rising-edge detected.
- swap_pending  out  1  swap requested but not yet performed.
- swap_done  out  1  one-cycle pulse on the cycle the swap takes effect.
- front_sel  out  1  index (0/1) of the buffer currently being scanned out.

## Operation

- Storage: two RAMs of FB_WIDTH*FB_HEIGHT x 16. The back buffer is the one selected by !front_sel.
- Address = y*FB_WIDTH + x, AW bits, unsigned. The product is computed in the capture stage.
- Write path: when fb_write=1, stage W1 registers {addr, color, buf = !front_sel}. Stage W2 writes RAM[buf][addr].
  - If fb_x >= FB_WIDTH or fb_y >= FB_HEIGHT, the write is dropped and no RAM change occurs.
- Read path: when disp_read=1, stage R1 registers {addr, buf = front_sel}. Stage R2 reads the RAM and registers disp_color, and pulses disp_valid.
  - Out-of-range reads return 16'h0000, with disp_valid still pulsed.
- Swap FSM states:
  - IDLE: a ctrl_swap rising edge moves to PENDING.
  - PENDING: a disp_vblank rising edge toggles front_sel, pulses swap_done and returns to IDLE.
  - swap_pending = (state == PENDING).
- A swap request arriving in the same cycle as a vblank rising edge swaps in that cycle.
- Further ctrl_swap edges while in PENDING are ignored; requests do not queue.
- A write already captured in W1 keeps its captured buf through a swap. It lands in the buffer that was back at capture time.
- Reads and writes in the same cycle never conflict: they target different buffers. The only exception is the in-flight case above, where the write wins and the read returns the old data.
- There is no backpressure. Writes are accepted every cycle and reads every cycle.

## Timing

- Reset (reset=0, asynchronous) sets: state IDLE, front_sel=0, swap_pending=0, swap_done=0, disp_valid=0, disp_color=0, W1/R1 valid bits 0, and the edge-detect registers to 0. RAM contents are not reset.
- Write latency: fb_write sampled at edge N; RAM updated at edge N+1. A read of the same buffer issued at edge N+1 or later sees the new data.
- Read latency: disp_read sampled at edge N; disp_color and disp_valid are asserted after edge N+2 for one cycle. The pipeline is fully pipelined (throughput 1 per cycle).
- Swap: the vblank rising edge is detected at edge M, and front_sel toggles at edge M. Reads sampled at M+1 or later use the new front. swap_done is high for the cycle after edge M.
- Reset asserted mid-operation aborts pending writes and reads in the pipeline; in-flight data is lost.

## Test plan

- Reset then idle: hold reset=0 for 3 cycles, then release → front_sel=0, swap_pending=0, disp_valid=0, disp_color=0.
- Write/readback across swap:
  - Write (10,20)=16'hABCD (goes to buffer 1), pulse ctrl_swap, then raise disp_vblank.
  - Read (10,20) → disp_color=16'hABCD two cycles after disp_read, with front_sel=1.
- Out-of-range drop: fb_x=400, fb_y=5, color 16'hFFFF → no RAM change; a read of (0,6) (address 2400, the aliased target) returns its prior value.
- Swap handshake corners:
  - ctrl_swap and a vblank edge in the same cycle → immediate toggle and swap_done pulse.
  - A second ctrl_swap while PENDING → only one toggle at the next vblank.
- Boundary address: write (399,239)=16'h1235, swap, read (399,239) → 16'h1235 at address 95999.
- In-flight write at swap: capture a write in the same cycle as the vblank edge → data appears in the old back buffer (now front). The new back buffer is unchanged at that address.
